// File: rtl/sram_rv_adapter.sv
// Ready/valid front end for a single-port synchronous SRAM with one-cycle read latency.
// Read responses land in a small circular FIFO; read credit guarantees it never overflows.
module sram_rv_adapter #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int RESP_DEPTH = 2
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int LAST  = RESP_DEPTH - 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam ptr_t             LAST_PTR = LAST[PTR_W-1:0];
  localparam logic [CNT_W:0]   DEPTH_C  = RESP_DEPTH[CNT_W:0];

  logic                  rd_pending_q, rd_pending_d;
  ptr_t                  wr_ptr_q, wr_ptr_d;
  ptr_t                  rd_ptr_q, rd_ptr_d;
  cnt_t                  count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [RESP_DEPTH];

  logic                  accept;
  logic                  rd_accept;
  logic                  push;
  logic                  pop;
  logic [CNT_W:0]        credit_used;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LAST_PTR) ? '0 : p + ptr_t'(1);
  endfunction

  // A read in flight already owns a FIFO slot; a same-cycle pop frees nothing yet.
  assign credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, rd_pending_q};
  assign req_ready   = rst0_n & (req_we | (credit_used < DEPTH_C));

  assign accept    = req_valid & req_ready;
  assign rd_accept = accept & ~req_we;

  assign csb0  = ~accept;
  assign web0  = ~(accept & req_we);
  assign addr0 = accept ? req_addr  : '0;
  assign din0  = accept ? req_wdata : '0;

  assign push      = rd_pending_q;
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_data  = mem_q[rd_ptr_q];

  always_comb begin
    rd_pending_d = rd_accept;
    wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d     = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      rd_pending_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      rd_pending_q <= rd_pending_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk0) begin
    if (push) begin
      mem_q[wr_ptr_q] <= dout0;
    end
  end

endmodule

// File: tb/tb_sram_rv_adapter.sv
// Self-checking bench: SRAM behavioural model plus a queue-based reference of outstanding reads.
module tb_sram_rv_adapter;

  localparam int DEPTH = 2;

  logic       clk0;
  logic       rst0_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [3:0] req_addr;
  logic [1:0] req_wdata;
  logic       csb0;
  logic       web0;
  logic [3:0] addr0;
  logic [1:0] din0;
  logic [1:0] dout0;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_data;

  int n_vec;
  int n_bad;

  // Reference state: memory contents in acceptance order, accepted reads not yet popped.
  logic [1:0] ref_mem [16];
  logic [1:0] exp_q [$];
  bit         inflight;

  logic [1:0] sram [16];

  sram_rv_adapter #(
    .DATA_WIDTH(2),
    .ADDR_WIDTH(4),
    .RESP_DEPTH(DEPTH)
  ) dut (
    .clk0     (clk0),
    .rst0_n   (rst0_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .csb0     (csb0),
    .web0     (web0),
    .addr0    (addr0),
    .din0     (din0),
    .dout0    (dout0),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  always @(posedge clk0) begin
    if (!csb0) begin
      if (!web0) sram[addr0] <= din0;
      else       dout0 <= sram[addr0];
    end
  end

  function automatic bit exp_ready();
    return req_we || (exp_q.size() < DEPTH);
  endfunction

  function automatic bit exp_rvalid();
    return exp_q.size() > int'(inflight);
  endfunction

  // Advance one rising edge and update the reference from the inputs presented.
  task automatic tick();
    bit acc;
    bit pp;
    logic [1:0] d;
    acc = req_valid && exp_ready();
    pp  = rsp_ready && exp_rvalid();
    @(posedge clk0);
    if (pp) begin
      d = exp_q.pop_front();
      $display("rsp  data=%0d", d);
    end
    if (acc) $display("req  we=%0d addr=%0d wdata=%0d", req_we, req_addr, req_wdata);
    if (acc && req_we)  ref_mem[req_addr] = req_wdata;
    if (acc && !req_we) exp_q.push_back(ref_mem[req_addr]);
    inflight = acc && !req_we;
    #1;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) tick();
  endtask

  task automatic test_reset();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_wdata = 2'd1; rsp_ready = 1'b1;
    @(negedge clk0);
    n_vec++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    n_vec++; if (csb0 !== 1'b1) begin n_bad++; $display("FAIL rst_csb0 got=%b exp=1", csb0); end
    n_vec++; if (web0 !== 1'b1) begin n_bad++; $display("FAIL rst_web0 got=%b exp=1", web0); end
    n_vec++; if (addr0 !== 4'd0 || din0 !== 2'd0) begin n_bad++; $display("FAIL rst_addr_din got=%0h/%0h exp=0/0", addr0, din0); end
    n_vec++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
    rst0_n = 1'b1;
    #1;
    n_vec++; if (req_ready !== 1'b1 || csb0 !== 1'b0) begin n_bad++; $display("FAIL rel_first_accept ready=%b csb0=%b exp=1/0", req_ready, csb0); end
    tick();
  endtask

  task automatic test_write_read();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd3; req_wdata = 2'b10; rsp_ready = 1'b1;
    @(negedge clk0);
    n_vec++; if (csb0 !== 1'b0 || web0 !== 1'b0) begin n_bad++; $display("FAIL wr_strobes csb0=%b web0=%b exp=0/0", csb0, web0); end
    n_vec++; if (addr0 !== 4'd3 || din0 !== 2'b10) begin n_bad++; $display("FAIL wr_bus addr0=%0d din0=%0d exp=3/2", addr0, din0); end
    tick();
    req_we = 1'b0;
    @(negedge clk0);
    n_vec++; if (csb0 !== 1'b0 || web0 !== 1'b1) begin n_bad++; $display("FAIL rd_strobes csb0=%b web0=%b exp=0/1", csb0, web0); end
    tick();
    req_valid = 1'b0;
    @(negedge clk0);
    n_vec++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_lat_early rsp_valid=%b exp=0", rsp_valid); end
    n_vec++; if (web0 !== 1'b1 || addr0 !== 4'd0 || din0 !== 2'd0) begin n_bad++; $display("FAIL idle_bus web0=%b addr0=%0d din0=%0d exp=1/0/0", web0, addr0, din0); end
    tick();
    @(negedge clk0);
    n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== 2'b10) begin n_bad++; $display("FAIL rd_lat_data valid=%b data=%0d exp=1/2", rsp_valid, rsp_data); end
    tick();
  endtask

  task automatic test_write_sweep();
    logic [1:0] d;
    req_valid = 1'b1; req_we = 1'b1; rsp_ready = 1'b1;
    for (int a = 0; a < 16; a++) begin
      d = 2'($urandom);
      req_addr = 4'(a); req_wdata = d;
      @(negedge clk0);
      n_vec++;
      if (csb0 !== 1'b0 || web0 !== 1'b0 || addr0 !== 4'(a) || din0 !== d) begin
        n_bad++;
        $display("FAIL sweep_wr a=%0d csb0=%b web0=%b addr0=%0d din0=%0d exp=0/0/%0d/%0d", a, csb0, web0, addr0, din0, a, d);
      end
      tick();
    end
    req_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int max_seen;
    rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_addr = 4'(7 + i);
      @(negedge clk0);
      n_vec++; if (req_ready !== 1'b1 || csb0 !== 1'b0) begin n_bad++; $display("FAIL bp_rd%0d ready=%b csb0=%b exp=1/0", i, req_ready, csb0); end
      tick();
    end
    req_addr = 4'd9;
    max_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk0);
      n_vec++; if (req_ready !== 1'b0 || csb0 !== 1'b1) begin n_bad++; $display("FAIL bp_stall%0d ready=%b csb0=%b exp=0/1", i, req_ready, csb0); end
      if (exp_q.size() > max_seen) max_seen = exp_q.size();
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk0);
    n_vec++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_pop_no_credit ready=%b exp=0", req_ready); end
    n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== ref_mem[7]) begin n_bad++; $display("FAIL bp_head valid=%b data=%0d exp=1/%0d", rsp_valid, rsp_data, ref_mem[7]); end
    tick();
    @(negedge clk0);
    n_vec++; if (req_ready !== 1'b1 || csb0 !== 1'b0) begin n_bad++; $display("FAIL bp_resume ready=%b csb0=%b exp=1/0", req_ready, csb0); end
    n_vec++; if (rsp_data !== ref_mem[8]) begin n_bad++; $display("FAIL bp_second data=%0d exp=%0d", rsp_data, ref_mem[8]); end
    tick();
    n_vec++; if (max_seen > DEPTH) begin n_bad++; $display("FAIL bp_count max=%0d exp<=%0d", max_seen, DEPTH); end
    drain();
  endtask

  task automatic test_stream();
    int k;
    int cyc;
    int acc_cyc;
    logic [1:0] got [$];
    rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0;
    for (int i = 0; i < 2; i++) begin req_addr = 4'(i); tick(); end
    k = 2; cyc = 0; acc_cyc = 999;
    rsp_ready = 1'b1;
    while ((k < 32 || got.size() < 32) && cyc < 150) begin
      req_valid = (k < 32);
      req_addr  = 4'(k % 16);
      @(negedge clk0);
      n_vec++; if (rsp_valid !== exp_rvalid()) begin n_bad++; $display("FAIL st_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rvalid()); end
      n_vec++; if (req_ready !== exp_ready()) begin n_bad++; $display("FAIL st_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready()); end
      if (rsp_valid) got.push_back(rsp_data);
      if (req_valid && exp_ready()) begin
        k++;
        if (k == 32) acc_cyc = cyc + 1;
      end
      tick();
      cyc++;
    end
    n_vec++; if (acc_cyc > 2 * 30 + 2) begin n_bad++; $display("FAIL st_rate cycles=%0d exp<=%0d", acc_cyc, 2 * 30 + 2); end
    n_vec++; if (got.size() != 32) begin n_bad++; $display("FAIL st_count got=%0d exp=32", got.size()); end
    for (int i = 0; i < got.size() && i < 32; i++) begin
      n_vec++;
      if (got[i] !== ref_mem[i % 16]) begin n_bad++; $display("FAIL st_order i=%0d got=%0d exp=%0d", i, got[i], ref_mem[i % 16]); end
    end
    drain();
  endtask

  task automatic test_writes_full();
    logic [1:0] d;
    rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0;
    for (int i = 0; i < 3; i++) begin req_addr = 4'(10 + i); tick(); end
    req_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = 2'($urandom);
      req_addr = 4'(i); req_wdata = d;
      @(negedge clk0);
      n_vec++;
      if (req_ready !== 1'b1 || csb0 !== 1'b0 || web0 !== 1'b0 || din0 !== d) begin
        n_bad++;
        $display("FAIL full_wr%0d ready=%b csb0=%b web0=%b din0=%0d exp=1/0/0/%0d", i, req_ready, csb0, web0, din0, d);
      end
      tick();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk0);
      n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== ref_mem[10 + i]) begin n_bad++; $display("FAIL full_drain%0d valid=%b data=%0d exp=1/%0d", i, rsp_valid, rsp_data, ref_mem[10 + i]); end
      tick();
    end
    drain();
  endtask

  task automatic test_reset_inflight();
    rsp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd4;
    tick();
    #2;
    rst0_n = 1'b0;
    #1;
    n_vec++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || csb0 !== 1'b1) begin n_bad++; $display("FAIL rstmid valid=%b ready=%b csb0=%b exp=0/0/1", rsp_valid, req_ready, csb0); end
    exp_q.delete();
    inflight = 1'b0;
    req_valid = 1'b0;
    @(negedge clk0);
    rst0_n = 1'b1;
    @(posedge clk0);
    #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk0);
      n_vec++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_ghost i=%0d valid=%b exp=0", i, rsp_valid); end
      tick();
    end
  endtask

  task automatic test_pop_capture();
    logic [1:0] d;
    d = 2'($urandom);
    req_valid = 1'b1; req_we = 1'b1; rsp_ready = 1'b0;
    req_addr = 4'd6; req_wdata = d;  tick();
    req_addr = 4'd9; req_wdata = ~d; tick();
    req_we = 1'b0; req_addr = 4'd6; tick();
    req_valid = 1'b0; tick();
    req_valid = 1'b1; req_addr = 4'd9; tick();
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk0);
    n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== d) begin n_bad++; $display("FAIL pc_before valid=%b data=%0d exp=1/%0d", rsp_valid, rsp_data, d); end
    tick();
    @(negedge clk0);
    n_vec++; if (rsp_valid !== 1'b1 || rsp_data !== ~d) begin n_bad++; $display("FAIL pc_after valid=%b data=%0d exp=1/%0d", rsp_valid, rsp_data, ~d); end
    tick();
    @(negedge clk0);
    n_vec++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL pc_count1 valid=%b exp=0", rsp_valid); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = 4'($urandom);
      req_wdata = 2'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk0);
      n_vec++; if (req_ready !== exp_ready()) begin n_bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready()); end
      n_vec++; if (rsp_valid !== exp_rvalid()) begin n_bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, rsp_valid, exp_rvalid()); end
      if (exp_rvalid()) begin
        n_vec++; if (rsp_data !== exp_q[0]) begin n_bad++; $display("FAIL rnd_data c=%0d got=%0d exp=%0d", c, rsp_data, exp_q[0]); end
      end
      n_vec++; if (csb0 !== !(req_valid && exp_ready())) begin n_bad++; $display("FAIL rnd_csb0 c=%0d got=%b exp=%b", c, csb0, !(req_valid && exp_ready())); end
      n_vec++; if (web0 !== !(req_valid && exp_ready() && req_we)) begin n_bad++; $display("FAIL rnd_web0 c=%0d got=%b exp=%b", c, web0, !(req_valid && exp_ready() && req_we)); end
      tick();
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_bad = 0; inflight = 1'b0;
    rst0_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    @(posedge clk0);
    @(posedge clk0);
    #1;
    test_reset();
    test_write_read();
    test_write_sweep();
    test_backpressure();
    test_stream();
    test_writes_full();
    test_reset_inflight();
    test_pop_capture();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_rv_adapter.md
SRAM_RV_ADAPTER -- requirements
Module: sram_rv_adapter

Interface
REQ-001 Parameter DATA_WIDTH, default 2, SHALL set the data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the word address width in bits.
REQ-003 Parameter RESP_DEPTH, default 2, SHALL set the response buffer entry count; legal values are 2 to 8.
REQ-004 clk0  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst0_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 req_valid  input  1  SHALL indicate a valid request.
REQ-007 req_ready  output  1  SHALL indicate the adapter accepts the request this cycle.
REQ-008 req_we  input  1  SHALL select write (1) or read (0).
REQ-009 req_addr  input  ADDR_WIDTH  SHALL carry the request word address.
REQ-010 req_wdata  input  DATA_WIDTH  SHALL carry the write data.
REQ-011 csb0  output  1  SHALL be the active-low SRAM chip select.
REQ-012 web0  output  1  SHALL be the active-low SRAM write enable.
REQ-013 addr0  output  ADDR_WIDTH  SHALL carry the SRAM address.
REQ-014 din0  output  DATA_WIDTH  SHALL carry the SRAM write data.
REQ-015 dout0  input  DATA_WIDTH  SHALL carry the SRAM read data, valid one clk0 cycle after the read is sampled.
REQ-016 rsp_valid  output  1  SHALL indicate read data is available.
REQ-017 rsp_ready  input  1  SHALL indicate the consumer takes the response.
REQ-018 rsp_data  output  DATA_WIDTH  SHALL carry the oldest read response.

Function
REQ-019 A request SHALL be accepted on any rising edge where req_valid and req_ready are both 1 (accept).
REQ-020 csb0 SHALL be 0 only in a cycle where an accept occurs; otherwise csb0 SHALL be 1.
REQ-021 In that cycle web0 SHALL equal ~req_we, and addr0 and din0 SHALL equal req_addr and req_wdata. In idle cycles web0 SHALL be 1 and addr0/din0 SHALL be 0.
REQ-022 A one-bit rd_pending register SHALL set on an accepted read and clear one cycle later unless another read is accepted.
REQ-023 When rd_pending is 1, dout0 SHALL be written into the response FIFO tail on that rising edge.
REQ-024 The response FIFO SHALL be circular, RESP_DEPTH entries deep, with wrap-around read and write pointers and a count 0..RESP_DEPTH.
REQ-025 rsp_valid SHALL equal (count != 0), and rsp_data SHALL be the head entry.
REQ-026 A response SHALL pop when rsp_valid and rsp_ready are both 1.
REQ-027 When a push and a pop occur in the same edge, count SHALL be unchanged and both pointers SHALL advance. This SHALL hold when count is RESP_DEPTH or 1.
REQ-028 Credit rule: req_ready SHALL be 1 when req_we is 1.
REQ-029 For a read, req_ready SHALL be 1 only if count + rd_pending < RESP_DEPTH. A pop in the current cycle does not add credit.
REQ-030 Writes SHALL produce no response and SHALL never be blocked.
REQ-031 The FIFO SHALL never overflow or drop captured data. FIFO full with another capture arriving SHALL be unreachable by construction.
REQ-032 Read latency SHALL be fixed: a read accepted at edge N, with an empty FIFO, SHALL raise rsp_valid after edge N+1.
REQ-033 Responses SHALL be returned in acceptance order.
REQ-034 A write and a read to the same address on consecutive accepts SHALL return the newly written data; the adapter relies on SRAM ordering and applies no hazard logic.

Reset
REQ-035 On rst0_n low, regardless of clock, the following SHALL clear: rd_pending, count, and both pointers.
REQ-036 While rst0_n is low: rsp_valid SHALL be 0, csb0 SHALL be 1, web0 SHALL be 1, addr0/din0 SHALL be 0, and req_ready SHALL be 0.
REQ-037 Reset asserted with a read in flight SHALL discard the read. No response SHALL appear after reset release.
REQ-038 FIFO storage SHALL need no reset.
REQ-039 After rst0_n release, the first accept SHALL be possible on the first rising edge.

Verification
REQ-040 Write addr 3 data 2'b10, then read addr 3, rsp_ready=1 -> csb0=0 and web0=0 on the write cycle; rsp_valid=1 with rsp_data=2'b10 exactly one cycle after the read accept.
REQ-041 rsp_ready=0, issue 3 back-to-back reads (RESP_DEPTH=2) -> third read stalled (req_ready=0, csb0=1) until the first pop; count never exceeds 2.
REQ-042 Full FIFO with rsp_ready=1 and a continuous read stream -> one read per two cycles is sustained, with no data loss and in-order data for addresses 0..15 wrapping twice.
REQ-043 Writes issued while the FIFO is full -> req_ready=1 and writes accepted every cycle.
REQ-044 Assert rst0_n mid-cycle one cycle after a read accept -> rsp_valid=0 immediately and no response after release.
REQ-045 Pop and capture on the same edge with count=1 -> count stays 1 and rsp_data becomes the new word.
